// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction-fetch stage. Owns the PC, issues I-cache reads, holds
//            across misses and drains an in-flight fill before a redirect.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h13)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallF,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] InstrF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  ValidF,
    output logic                  MissStallF
);

    localparam logic [DATA_WIDTH-1:0] c_pc_step = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_MISS  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_target;

    logic                  w_deliver;
    logic [DATA_WIDTH-1:0] w_pc_plus4;

    // Data arriving in DRAIN belongs to the abandoned path and is never delivered.
    assign w_deliver  = (r_state != S_DRAIN) && imem_ready;
    assign w_pc_plus4 = r_pc + c_pc_step;

    assign imem_req   = !rst;
    assign imem_addr  = r_pc;
    assign PCF        = r_pc;
    assign PCPlus4F   = w_pc_plus4;
    assign ValidF     = !rst && w_deliver;
    assign MissStallF = !rst && !w_deliver;
    assign InstrF     = ValidF ? imem_rdata : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_target <= '0;
        end else begin
            case (r_state)
                S_FETCH, S_MISS: begin
                    if (imem_ready) begin
                        r_state <= S_FETCH;
                        if (PCSrcE) begin
                            r_pc <= PCTargetE;
                        end else if (!StallF) begin
                            r_pc <= w_pc_plus4;
                        end
                    end else if (PCSrcE) begin
                        // Let the outstanding fill finish before jumping away.
                        r_target <= PCTargetE;
                        r_state  <= S_DRAIN;
                    end else begin
                        r_state <= S_MISS;
                    end
                end
                S_DRAIN: begin
                    if (imem_ready) begin
                        r_pc    <= PCSrcE ? PCTargetE : r_target;
                        r_state <= S_FETCH;
                    end else if (PCSrcE) begin
                        r_target <= PCTargetE;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
